// File: rtl/oka_mac8_pipe.sv
// rtl/oka_mac8_pipe.sv - streaming dot-product accumulator around an 8-bit truncated multiplier.
// Define OKA_MAC_SAT_EN for a saturating accumulator; the default build wraps.
module oka_mac8_pipe #(
   parameter int WIDTH = 8,
   parameter int ACC_W = 16,
   parameter int LEN_W = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [ACC_W-1:0] res_data,
   output logic             ovf,
   output logic             busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   logic [LEN_W-1:0] r_len_q;
   logic [LEN_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_s1_a;
   logic [WIDTH-1:0] r_s1_b;
   logic             r_s1_v;
   logic [WIDTH-1:0] r_p_q;
   logic             r_s2_v;
   logic [ACC_W-1:0] r_acc;
   logic             r_ovf;

   logic             w_accept;
   logic             w_start;
   logic             w_last;
   logic [LEN_W-1:0] w_cnt_nxt;
   logic [WIDTH-1:0] w_prod;
   logic [ACC_W:0]   w_p_ext;
   logic [ACC_W:0]   w_sum;

   assign w_accept  = in_valid & (r_state == S_RUN);
   assign w_start   = start & (r_state == S_IDLE);
   assign w_cnt_nxt = r_cnt + LEN_W'(1);
   assign w_last    = w_accept & (w_cnt_nxt == r_len_q);

   // Only the low WIDTH bits of the product are ever formed.
   assign w_prod  = r_s1_a * r_s1_b;
   assign w_p_ext = (ACC_W + 1)'(r_p_q);
   assign w_sum   = {1'b0, r_acc} + w_p_ext;

   assign in_ready  = (r_state == S_RUN);
   assign res_valid = (r_state == S_DONE);
   assign busy      = (r_state != S_IDLE);
   assign res_data  = r_acc;
   assign ovf       = r_ovf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = (len == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (w_last) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (!r_s1_v && !r_s2_v) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (res_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_len_q <= '0;
         r_cnt   <= '0;
         r_s1_a  <= '0;
         r_s1_b  <= '0;
         r_s1_v  <= 1'b0;
         r_p_q   <= '0;
         r_s2_v  <= 1'b0;
         r_acc   <= '0;
         r_ovf   <= 1'b0;
      end else begin
         r_s1_v <= w_accept;
         if (w_accept) begin
            r_s1_a <= in_a;
            r_s1_b <= in_b;
         end
         r_s2_v <= r_s1_v;
         if (r_s1_v) begin
            r_p_q <= w_prod;
         end
         // The pipeline is empty in IDLE, so a start never races an accumulate.
         if (w_start) begin
            r_len_q <= len;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
         end else begin
            if (w_accept) begin
               r_cnt <= w_cnt_nxt;
            end
            if (r_s2_v) begin
`ifdef OKA_MAC_SAT_EN
               if (w_sum[ACC_W]) begin
                  r_acc <= '1;
                  r_ovf <= 1'b1;
               end else begin
                  r_acc <= w_sum[ACC_W-1:0];
               end
`else
               r_acc <= w_sum[ACC_W-1:0];
               if (w_sum[ACC_W]) begin
                  r_ovf <= 1'b1;
               end
`endif
            end
         end
      end
   end

endmodule
